// File: rtl/fetch_unit.sv
// In-order instruction fetch stage: owns the fetch PC, issues word requests to
// instruction memory and hands fetched words to decode through a small PC-tagged queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    localparam int          IW      = $clog2(QUEUE_DEPTH);
    localparam int          PW      = IW + 1;
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(QUEUE_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]            fetch_pc;
    logic [PW-1:0]          alloc_ptr, fill_ptr, read_ptr, discard_cnt;
    logic [31:0]            q_pc   [QUEUE_DEPTH];
    logic [31:0]            q_data [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_filled;

    logic [IW-1:0] alloc_idx, fill_idx, read_idx;
    logic [PW-1:0] allocated, outstanding, discard_next;
    logic [PW:0]   budget, discard_sum;
    logic          empty, req_fire, rsp_fill, pop;

    assign alloc_idx   = alloc_ptr[IW-1:0];
    assign fill_idx    = fill_ptr[IW-1:0];
    assign read_idx    = read_ptr[IW-1:0];
    assign allocated   = alloc_ptr - read_ptr;
    assign outstanding = alloc_ptr - fill_ptr;
    assign empty       = (alloc_ptr == read_ptr);

    // Stale responses still owed by memory occupy queue budget so in-flight never exceeds depth.
    assign budget         = {1'b0, allocated} + {1'b0, discard_cnt};
    assign imem_req_valid = reset_n && !redirect_valid && (budget < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fill = imem_rsp_valid && !redirect_valid && (discard_cnt == '0);

    assign out_valid       = !redirect_valid && q_filled[read_idx] && !empty;
    assign out_instruction = out_valid ? q_data[read_idx] : NOP;
    assign out_pc          = out_valid ? q_pc[read_idx] : 32'h0;
    assign pop             = out_valid && out_ready;

    // A response landing in the redirect cycle retires one of the owed responses.
    assign discard_sum  = {1'b0, discard_cnt} + {1'b0, outstanding};
    assign discard_next = (imem_rsp_valid && discard_sum != '0)
                        ? PW'(discard_sum - (PW + 1)'(1))
                        : PW'(discard_sum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            discard_cnt <= '0;
            q_filled    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            discard_cnt <= discard_next;
            q_filled    <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc            <= fetch_pc + 32'd4;
                alloc_ptr           <= alloc_ptr + PW'(1);
                q_filled[alloc_idx] <= 1'b0;
            end
            if (imem_rsp_valid) begin
                if (discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - PW'(1);
                end else begin
                    fill_ptr           <= fill_ptr + PW'(1);
                    q_filled[fill_idx] <= 1'b1;
                end
            end
            if (pop) begin
                read_ptr <= read_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            q_pc[alloc_idx] <= fetch_pc;
        end
        if (rsp_fill) begin
            q_data[fill_idx] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model with random latency and
// an epoch-based reference of the request and instruction streams.
module tb_fetch_unit;

    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instruction, out_pc;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend[$];
    int          cyc, cur_epoch, acc_ep, rcv_ep, pop_ep, last_due;
    logic [31:0] req_pc, exp_pc;
    int          lat_min, lat_max, rdy_pct, ordy_pct;
    int          nvec, nerr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Called at a falling edge; leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instruction, NOP);
        check("rst_out_pc", out_pc, 32'h0);
        pend.delete();
        cur_epoch++;
        acc_ep = 0; rcv_ep = 0; pop_ep = 0;
        req_pc = RPC; exp_pc = RPC;
        last_due = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc);
        int   stale, lat, due;
        bit   exp_rv, exp_ov, rsp;
        req_t p;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ordy_pct);
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp            = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom();
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != cur_epoch) stale++;
        exp_rv = !redir && ((acc_ep - pop_ep + stale) < D);
        exp_ov = !redir && (rcv_ep > pop_ep);
        #1;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("req_addr", imem_req_addr, req_pc);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc", out_pc, exp_pc);
            check("out_instr", out_instruction, mem_word(exp_pc));
        end else begin
            check("idle_pc", out_pc, 32'h0);
            check("idle_instr", out_instruction, NOP);
        end
        if (rsp) begin
            p = pend.pop_front();
            if (!redir && p.epoch == cur_epoch) rcv_ep++;
        end
        if (exp_rv && imem_req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{req_pc, cur_epoch, due});
            last_due = due;
            acc_ep++;
            req_pc += 32'd4;
        end
        if (exp_ov && out_ready) begin
            pop_ep++;
            exp_pc += 32'd4;
        end
        if (redir) begin
            cur_epoch++;
            acc_ep = 0; rcv_ep = 0; pop_ep = 0;
            req_pc = {rpc[31:2], 2'b00};
            exp_pc = req_pc;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    initial begin
        nvec = 0; nerr = 0; cyc = 0; cur_epoch = 0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100;
        @(negedge clk);

        // streaming at latency 1
        do_reset();
        run(20);

        // back-pressure: queue fills, then one pop admits one request
        do_reset();
        ordy_pct = 0;
        run(8);
        ordy_pct = 100;
        run(1);
        ordy_pct = 0;
        run(5);

        // redirect with three requests in flight, none returning in the redirect cycle
        do_reset();
        ordy_pct = 100; lat_min = 4; lat_max = 4;
        run(3);
        step(1'b1, 32'h0000_0102);
        run(14);

        // redirect coinciding with a response
        do_reset();
        lat_min = 3; lat_max = 3;
        run(3);
        step(1'b1, 32'h0000_0200);
        run(14);

        // address wrap
        do_reset();
        lat_min = 1; lat_max = 1;
        run(2);
        step(1'b1, 32'hFFFF_FFFC);
        run(10);

        // random ready, latency, back-pressure, redirects and occasional reset
        do_reset();
        lat_min = 1; lat_max = 4; rdy_pct = 60; ordy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) == 0) do_reset();
            else if ($urandom_range(99) < 4) step(1'b1, $urandom());
            else step(1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
